id_ex_pipeline_reg: RTL
=======================

# id_ex_pipeline_reg

ID/EX pipeline register of the five-stage MIPS CPU, with integrated load-use hazard detection. It captures decoded operands, register specifiers and control bits from ID, inserts bubbles on load-use hazards or EX-resolved branch flushes, and holds on downstream stall. Its registered `ID_EX_RegisterRs/Rt/Rd` and control outputs feed the forwarding unit and the EX stage. Cycle counters for stalls and flushes are included for performance measurement.

## Interface
- `DATA_W`, 32: operand, immediate and PC width.
- `CNT_W`, 32: width of the performance counters.
- `CLK`  in  1  clock; all state updates on the rising edge.
- `RESET`  in  1  synchronous, active-high reset.
- `IF_ID_RegisterRs`, `IF_ID_RegisterRt`, `IF_ID_RegisterRd`  in  5 each  specifiers of the instruction in ID.
- `ID_RegWrite`, `ID_MemRead`, `ID_MemWrite`, `ID_MemtoReg`, `ID_ALUSrc`, `ID_RegDst`  in  1 each  decoded control.
- `ID_ALUOp`  in  4  ALU operation code.
- `ID_ReadData1`, `ID_ReadData2`, `ID_SignExtImm`, `ID_PCPlus4`  in  DATA_W each  ID operands.
- `ID_Shamt`  in  5  shift amount.
- `FlushEX`  in  1  branch/jump taken; kill the instruction entering EX.
- `HoldEX`  in  1  downstream (memory) stall; freeze the register.
- `ID_EX_*`  out  registered copies of every ID input above (same names, `ID_EX_` prefix; specifiers as `ID_EX_RegisterRs/Rt/Rd`).
- `ID_EX_Valid`  out  1  register holds a real instruction (0 = bubble).
- `LoadUseStall`  out  1  combinational; freeze PC and IF/ID this cycle.
- `StallCount`, `FlushCount`  out  CNT_W  saturating event counters.

## Operation
- Control bundle = {RegWrite, MemRead, MemWrite, MemtoReg, ALUSrc, RegDst, ALUOp}. A bubble zeroes the bundle and `Valid`; data/specifier fields in a bubble are also zeroed (so `ID_EX_RegisterRd` = 0 never triggers forwarding).
- Load-use: `LoadUseStall` = `ID_EX_Valid & ID_EX_MemRead & (ID_EX_RegisterRt != 0) & (ID_EX_RegisterRt == IF_ID_RegisterRs | ID_EX_RegisterRt == IF_ID_RegisterRt)`. Forced to 0 while `FlushEX` = 1 (younger instruction is being killed anyway).
- Next-state priority per cycle: `RESET` > `FlushEX` (load bubble) > `HoldEX` (keep contents) > `LoadUseStall` (load bubble) > load ID inputs with `Valid`=1.
- `HoldEX` with `LoadUseStall`: register holds; `LoadUseStall` stays asserted, so the bubble is inserted on the first non-held cycle.
- `StallCount` increments on each cycle where `LoadUseStall` = 1 and `HoldEX` = 0; `FlushCount` increments on each `FlushEX` cycle; both saturate at all-ones, never wrap.

## Timing
- Reset values: all `ID_EX_*` = 0, `ID_EX_Valid` = 0, counters = 0; `LoadUseStall` = 0 (since Valid = 0).
- Latency: ID inputs visible on `ID_EX_*` one cycle after the capturing edge.
- Load-use stall lasts exactly one cycle absent `HoldEX`: the bubble clears `ID_EX_MemRead`, deasserting the stall.
- Back-to-back loads with dependencies: each dependent pair yields exactly one bubble.
- `RESET` asserted mid-stall or mid-hold: contents and counters cleared on that edge; no state carried over.
- `FlushEX` and `HoldEX` together: flush wins, bubble loaded.

## Structure
- Shared package: control-bundle width constant (10), field bit offsets within the bundle, the all-zero bubble constant, and the `$zero` register index.
- One sub-module: `load_use_detector` (purely combinational compare producing `LoadUseStall`); registers and counters stay in the top.

## Test plan
- Reset: hold `RESET` 2 cycles with random ID inputs -> all outputs 0, `LoadUseStall` 0, counters 0.
- `lw $2,0($1)` then `add $4,$2,$5` -> `LoadUseStall`=1 for exactly one cycle, next ID_EX is bubble (Valid 0, RegWrite 0), then add loads; `StallCount`=1.
- `lw $0,0($1)` then `add $4,$0,$5` -> no stall, `StallCount`=0.
- Load-use with `HoldEX`=1 for 3 cycles -> register unchanged 3 cycles, `LoadUseStall` high 4 cycles, one bubble after hold drops, `StallCount`=1.
- `FlushEX`=1 with valid `add $3,$1,$2` in ID -> next ID_EX Valid 0, RegisterRd 0; `FlushCount`=1; `FlushEX` with `HoldEX` same result.
- Preload `StallCount`=all-ones via 2^CNT_W stalls (CNT_W=4 build) -> stays 15, no wrap.

Source files
------------

// File: rtl/id_ex_pipeline_reg_pkg.sv
// id_ex_pipeline_reg_pkg: control-bundle layout and bubble constants shared by the ID/EX register slice.
package id_ex_pipeline_reg_pkg;
    localparam int CTRL_W       = 10;
    localparam int REGWRITE_BIT = 9;
    localparam int MEMREAD_BIT  = 8;
    localparam int MEMWRITE_BIT = 7;
    localparam int MEMTOREG_BIT = 6;
    localparam int ALUSRC_BIT   = 5;
    localparam int REGDST_BIT   = 4;
    localparam int ALUOP_LSB    = 0;
    localparam int ALUOP_W      = 4;
    typedef logic [CTRL_W-1:0] ctrl_t;
    localparam ctrl_t      BUBBLE_CTRL = '0;
    localparam logic [4:0] ZERO_REG    = 5'd0;
    function automatic ctrl_t pack_ctrl(
        input logic rw, input logic mr, input logic mw, input logic m2r,
        input logic asrc, input logic rdst, input logic [ALUOP_W-1:0] op
    );
        return {rw, mr, mw, m2r, asrc, rdst, op};
    endfunction
endpackage

// File: rtl/id_ex_pipeline_reg_load_use_detector.sv
// load_use_detector: flags a load in EX whose destination is read by the instruction in ID.
module load_use_detector
    import id_ex_pipeline_reg_pkg::*;
(
    input  logic       ex_valid,
    input  logic       ex_mem_read,
    input  logic [4:0] ex_rt,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       flush,
    output logic       stall
);
    // A flush kills the dependent instruction, so no freeze is needed.
    assign stall = !flush && ex_valid && ex_mem_read && (ex_rt != ZERO_REG)
                   && ((ex_rt == id_rs) || (ex_rt == id_rt));
endmodule

// File: rtl/id_ex_pipeline_reg.sv
// id_ex_pipeline_reg: ID/EX register with load-use bubble insertion, flush, hold and saturating event counters.
module id_ex_pipeline_reg
    import id_ex_pipeline_reg_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 32
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [4:0]        IF_ID_RegisterRs,
    input  logic [4:0]        IF_ID_RegisterRt,
    input  logic [4:0]        IF_ID_RegisterRd,
    input  logic              ID_RegWrite,
    input  logic              ID_MemRead,
    input  logic              ID_MemWrite,
    input  logic              ID_MemtoReg,
    input  logic              ID_ALUSrc,
    input  logic              ID_RegDst,
    input  logic [3:0]        ID_ALUOp,
    input  logic [DATA_W-1:0] ID_ReadData1,
    input  logic [DATA_W-1:0] ID_ReadData2,
    input  logic [DATA_W-1:0] ID_SignExtImm,
    input  logic [DATA_W-1:0] ID_PCPlus4,
    input  logic [4:0]        ID_Shamt,
    input  logic              FlushEX,
    input  logic              HoldEX,
    output logic [4:0]        ID_EX_RegisterRs,
    output logic [4:0]        ID_EX_RegisterRt,
    output logic [4:0]        ID_EX_RegisterRd,
    output logic              ID_EX_RegWrite,
    output logic              ID_EX_MemRead,
    output logic              ID_EX_MemWrite,
    output logic              ID_EX_MemtoReg,
    output logic              ID_EX_ALUSrc,
    output logic              ID_EX_RegDst,
    output logic [3:0]        ID_EX_ALUOp,
    output logic [DATA_W-1:0] ID_EX_ReadData1,
    output logic [DATA_W-1:0] ID_EX_ReadData2,
    output logic [DATA_W-1:0] ID_EX_SignExtImm,
    output logic [DATA_W-1:0] ID_EX_PCPlus4,
    output logic [4:0]        ID_EX_Shamt,
    output logic              ID_EX_Valid,
    output logic              LoadUseStall,
    output logic [CNT_W-1:0]  StallCount,
    output logic [CNT_W-1:0]  FlushCount
);
    ctrl_t ctrl_q;
    logic  bubble;

    load_use_detector u_lud (
        .ex_valid    (ID_EX_Valid),
        .ex_mem_read (ID_EX_MemRead),
        .ex_rt       (ID_EX_RegisterRt),
        .id_rs       (IF_ID_RegisterRs),
        .id_rt       (IF_ID_RegisterRt),
        .flush       (FlushEX),
        .stall       (LoadUseStall)
    );

    // Hold outranks the load-use bubble, so the bubble lands on the first unheld edge.
    assign bubble = RESET || FlushEX || (!HoldEX && LoadUseStall);

    always_ff @(posedge CLK) begin
        if (bubble) begin
            ID_EX_Valid      <= 1'b0;
            ctrl_q           <= BUBBLE_CTRL;
            ID_EX_RegisterRs <= ZERO_REG;
            ID_EX_RegisterRt <= ZERO_REG;
            ID_EX_RegisterRd <= ZERO_REG;
            ID_EX_ReadData1  <= '0;
            ID_EX_ReadData2  <= '0;
            ID_EX_SignExtImm <= '0;
            ID_EX_PCPlus4    <= '0;
            ID_EX_Shamt      <= '0;
        end else if (!HoldEX) begin
            ID_EX_Valid      <= 1'b1;
            ctrl_q           <= pack_ctrl(ID_RegWrite, ID_MemRead, ID_MemWrite, ID_MemtoReg,
                                          ID_ALUSrc, ID_RegDst, ID_ALUOp);
            ID_EX_RegisterRs <= IF_ID_RegisterRs;
            ID_EX_RegisterRt <= IF_ID_RegisterRt;
            ID_EX_RegisterRd <= IF_ID_RegisterRd;
            ID_EX_ReadData1  <= ID_ReadData1;
            ID_EX_ReadData2  <= ID_ReadData2;
            ID_EX_SignExtImm <= ID_SignExtImm;
            ID_EX_PCPlus4    <= ID_PCPlus4;
            ID_EX_Shamt      <= ID_Shamt;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            StallCount <= '0;
            FlushCount <= '0;
        end else begin
            if (LoadUseStall && !HoldEX && StallCount != '1) StallCount <= StallCount + CNT_W'(1);
            if (FlushEX && FlushCount != '1) FlushCount <= FlushCount + CNT_W'(1);
        end
    end

    assign ID_EX_RegWrite = ctrl_q[REGWRITE_BIT];
    assign ID_EX_MemRead  = ctrl_q[MEMREAD_BIT];
    assign ID_EX_MemWrite = ctrl_q[MEMWRITE_BIT];
    assign ID_EX_MemtoReg = ctrl_q[MEMTOREG_BIT];
    assign ID_EX_ALUSrc   = ctrl_q[ALUSRC_BIT];
    assign ID_EX_RegDst   = ctrl_q[REGDST_BIT];
    assign ID_EX_ALUOp    = ctrl_q[ALUOP_LSB +: ALUOP_W];
endmodule
